mem_arbiter: RTL
================

# mem_arbiter

Two-requester arbiter and access sequencer for the 32-entry register-style data memory (one write port, two read ports, level-sensitive MemRead/MemWrite). It accepts read/write requests from two masters (requester 0 = CPU load/store path, requester 1 = loader/debug port), selects one by round-robin, and drives registered, single-cycle memory strobes. It returns read data with a valid pulse and keeps per-requester grant counters. It sits between the masters and the memory; nothing else drives the memory's address, data or strobe pins.

## Interface
- N, 32, data width; must match memory word width
- AW, 5, address width (32 entries)
- CW, 16, width of each grant counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- req0 / req1  in  1  access request, held until matching gnt
- we0 / we1  in  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  in  AW  word address; stable while req high
- wdata0 / wdata1  in  N  write data; stable while req high
- gnt0 / gnt1  out  1  one-cycle pulse: access issued this cycle
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata valid
- rdata0 / rdata1  out  N  registered read data, held until next read for that requester
- gcnt0 / gcnt1  out  CW  saturating count of grants per requester
- mem_addr, mem_addr2  out  AW  to memory addr / addr2
- mem_wdata  out  N  to memory write_data
- mem_read, mem_write  out  1  to memory MemRead / MemWrite
- mem_rdata, mem_rdata2  in  N  from memory read_data / read_data2

## Operation
- FSM states: IDLE, ISSUE.
- IDLE:
  - No req: stay in IDLE.
  - Any req: pick a winner. Register its addr/wdata/we into the mem_* output registers. Go to ISSUE.
- ISSUE:
  - Exactly one of mem_read/mem_write is high. gnt of the winner is high.
  - For a read, mem_rdata is captured into the winner's rdata at the end of this cycle.
  - Always return to IDLE.
- Outputs:
  - All mem_* outputs are driven from flops, so the memory's level-sensitive write sees no glitches.
  - mem_read and mem_write are never high together.
  - In IDLE both strobes are 0, and mem_addr/mem_addr2/mem_wdata hold their last value.
- Round-robin:
  - 1-bit pointer prio, 0 after reset.
  - Both requesting: winner = prio.
  - One requesting: it wins.
  - After any single grant, prio = other requester.
- Inputs are sampled only in IDLE. Changes during ISSUE are ignored.
- A req dropped before grant is simply not served. No error is raised.
- A requester sees gnt in ISSUE and must drop req at the next edge, otherwise it is treated as a new request.
- Counters: gcntX increments on each gntX and saturates at 2^CW-1.
- Reset, including mid-ISSUE:
  - state=IDLE, mem_read=mem_write=0, gnt*=0, rvalid*=0, rdata*=0, prio=0, gcnt*=0, mem_addr=mem_addr2=0, mem_wdata=0.
  - An interrupted access gets no rvalid.

## Timing
- Request sampled at edge t (IDLE) -> ISSUE during t+1 (gnt, strobe) -> rvalid/rdata during t+2 (reads only).
- Writes: the memory is updated during the ISSUE cycle. No rvalid is generated.
- Throughput: one access per 2 cycles.
- Back-to-back contention alternates grants: 0,1,0,1 when prio=0 initially.
- Worst-case wait for a continuously requesting master: 4 cycles from req to gnt.

## Configuration
- MEM_ARB_DUAL_READ_EN defined:
  - Trigger: both requesters request reads in the same IDLE sample.
  - Both are issued in one ISSUE: addr0 on mem_addr, addr1 on mem_addr2, mem_read=1.
  - gnt0 and gnt1 pulse together; rvalid0 and rvalid1 pulse together (rdata1 from mem_rdata2).
  - Both counters increment; prio is unchanged.
- Not defined:
  - mem_addr2 is tied to mem_addr and mem_rdata2 is unused.
  - All contention is serialized by round-robin.

## Structure
- Package mem_arb_pkg:
  - FSM state encoding (IDLE, ISSUE).
  - Default AW, N, CW.
  - Requester index constants REQ_CPU=0, REQ_LDR=1.
- Sub-module rr_pick2:
  - Combinational 2-way round-robin picker.
  - Inputs: req0, req1, prio. Outputs: win_valid, win_idx.
  - The arbiter holds the prio register and the FSM.

## Test plan
- Reset: rst high 2 cycles while req0=1 -> all outputs 0, no gnt. First gnt0 appears in the 2nd cycle after rst drops.
- Single write then read:
  - req0 write addr=3, wdata=0xA5 -> gnt0 and mem_write=1 for one cycle, mem_addr=3.
  - Then req0 read addr=3 -> rvalid0 one cycle later, rdata0=0xA5.
- Contention, macro off:
  - req0 and req1 both held, reads of addr 0/1 (mem preloaded 1,2).
  - Grants alternate gnt0, gnt1, gnt0 every 2 cycles.
  - rdata0=1, rdata1=2; gcnt0/gcnt1 track the grants.
- Dual read, macro on:
  - Both read, addr0=2, addr1=30 (preloaded 3, 60).
  - gnt0 and gnt1 in the same cycle; next cycle rvalid0=rvalid1=1, rdata0=3, rdata1=60; prio unchanged.
- Mixed, macro on: req0 write addr=5, req1 read addr=5 simultaneously -> serialized, never dual-issued; mem_read and mem_write never both high.
- Reset mid-ISSUE and saturation:
  - rst asserted during ISSUE of a read -> no rvalid, rdata=0.
  - With CW=2, 5 grants to req0 -> gcnt0 stays 3.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the two-requester memory
//               arbiter: FSM state encoding, default widths and requester
//               index constants.
// Contents    : arb_state_t (IDLE, ISSUE), DEF_N / DEF_AW / DEF_CW,
//               REQ_CPU / REQ_LDR.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  localparam int DEF_N  = 32;   // memory word width
  localparam int DEF_AW = 5;    // 32-entry word address
  localparam int DEF_CW = 16;   // grant counter width

  localparam logic REQ_CPU = 1'b0;  // requester 0: CPU load/store path
  localparam logic REQ_LDR = 1'b1;  // requester 1: loader/debug port

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_if
// Description : Bundle of requester-side and memory-side signals of the
//               memory arbiter.
// Modports    : slave  - arbiter view (requests and memory read data in;
//                        grants, read returns, counters and strobes out)
//               master - requesters/memory view (the opposite directions)
// Signals     : req/we/addr/wdata 0,1 ; gnt/rvalid/rdata/gcnt 0,1 ;
//               mem_addr, mem_addr2, mem_wdata, mem_read, mem_write,
//               mem_rdata, mem_rdata2
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arb_if #(
  parameter int N  = mem_arb_pkg::DEF_N,
  parameter int AW = mem_arb_pkg::DEF_AW,
  parameter int CW = mem_arb_pkg::DEF_CW
) ();

  logic          req0,    req1;
  logic          we0,     we1;
  logic [AW-1:0] addr0,   addr1;
  logic [N-1:0]  wdata0,  wdata1;
  logic          gnt0,    gnt1;
  logic          rvalid0, rvalid1;
  logic [N-1:0]  rdata0,  rdata1;
  logic [CW-1:0] gcnt0,   gcnt1;
  logic [AW-1:0] mem_addr, mem_addr2;
  logic [N-1:0]  mem_wdata;
  logic          mem_read, mem_write;
  logic [N-1:0]  mem_rdata, mem_rdata2;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  mem_rdata, mem_rdata2,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, gcnt0, gcnt1,
    output mem_addr, mem_addr2, mem_wdata, mem_read, mem_write
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output mem_rdata, mem_rdata2,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, gcnt0, gcnt1,
    input  mem_addr, mem_addr2, mem_wdata, mem_read, mem_write
  );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational two-way round-robin picker. When both inputs
//               request, the one named by i_prio wins; otherwise the single
//               requester wins.
// Ports       : i_req0, i_req1 - requests
//               i_prio         - preferred requester on contention
//               o_win_valid    - at least one request present
//               o_win_idx      - index of the winner
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2
  import mem_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_prio,
  output logic o_win_valid,
  output logic o_win_idx
);

  assign o_win_valid = i_req0 | i_req1;
  assign o_win_idx   = (i_req0 & i_req1) ? i_prio
                     : (i_req1 ? REQ_LDR : REQ_CPU);

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester round-robin arbiter and access sequencer for a
//               32-entry register-style data memory. Each access takes an
//               IDLE (sample) cycle and an ISSUE (strobe) cycle; all memory
//               pins are driven from flops.
// Ports       : clk, rst (synchronous, active-high)
//               bus (mem_arb_if.slave) - requester and memory signals
// Config      : MEM_ARB_DUAL_READ_EN - when defined, two simultaneous reads
//               are issued together on mem_addr / mem_addr2.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int AW = DEF_AW,
  parameter int CW = DEF_CW
) (
  input  logic       clk,
  input  logic       rst,
  mem_arb_if.slave   bus
);

  arb_state_t    r_state, w_next_state;
  logic          r_prio;
  logic          w_win_valid, w_win_idx, w_dual, w_take;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [N-1:0]  w_sel_wdata;
  logic [AW-1:0] r_mem_addr;
  logic [N-1:0]  r_mem_wdata;
  logic          r_mem_read, r_mem_write;
  logic          r_gnt0, r_gnt1, r_rvalid0, r_rvalid1;
  logic [N-1:0]  r_rdata0, r_rdata1;
  logic [CW-1:0] r_gcnt0, r_gcnt1;

  rr_pick2 u_pick (
    .i_req0      (bus.req0),
    .i_req1      (bus.req1),
    .i_prio      (r_prio),
    .o_win_valid (w_win_valid),
    .o_win_idx   (w_win_idx)
  );

`ifdef MEM_ARB_DUAL_READ_EN
  logic [AW-1:0] r_mem_addr2;
  assign w_dual        = bus.req0 & bus.req1 & ~bus.we0 & ~bus.we1;
  assign bus.mem_addr2 = r_mem_addr2;
`else
  logic [N-1:0] w_unused_rdata2;
  assign w_dual          = 1'b0;
  assign w_unused_rdata2 = bus.mem_rdata2;
  assign bus.mem_addr2   = r_mem_addr;
`endif

  assign w_sel_we    = (w_win_idx == REQ_LDR) ? bus.we1    : bus.we0;
  assign w_sel_addr  = (w_win_idx == REQ_LDR) ? bus.addr1  : bus.addr0;
  assign w_sel_wdata = (w_win_idx == REQ_LDR) ? bus.wdata1 : bus.wdata0;

  // Requests are only looked at in IDLE; anything seen during ISSUE is ignored.
  assign w_take = (r_state == IDLE) && w_win_valid;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_win_valid) w_next_state = ISSUE;
      ISSUE:   w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio      <= REQ_CPU;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
      r_gcnt0     <= '0;
      r_gcnt1     <= '0;
`ifdef MEM_ARB_DUAL_READ_EN
      r_mem_addr2 <= '0;
`endif
    end else begin
      // Pulses default low; address/data registers keep their last value.
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;

      if (w_take) begin
        r_mem_addr  <= w_dual ? bus.addr0 : w_sel_addr;
        r_mem_wdata <= w_sel_wdata;
        r_mem_read  <= w_dual | ~w_sel_we;
        r_mem_write <= ~w_dual & w_sel_we;
        r_gnt0      <= w_dual | (w_win_idx == REQ_CPU);
        r_gnt1      <= w_dual | (w_win_idx == REQ_LDR);
        // A dual issue serves both sides, so fairness is unaffected.
        if (!w_dual) r_prio <= ~w_win_idx;
`ifdef MEM_ARB_DUAL_READ_EN
        r_mem_addr2 <= w_dual ? bus.addr1 : w_sel_addr;
`endif
      end

      if ((r_state == ISSUE) && r_mem_read) begin
        if (r_gnt0) begin
          r_rvalid0 <= 1'b1;
          r_rdata0  <= bus.mem_rdata;
        end
        if (r_gnt1) begin
          r_rvalid1 <= 1'b1;
`ifdef MEM_ARB_DUAL_READ_EN
          // Both grants at once only happens on a dual issue: port 2 is ours.
          r_rdata1  <= r_gnt0 ? bus.mem_rdata2 : bus.mem_rdata;
`else
          r_rdata1  <= bus.mem_rdata;
`endif
        end
      end

      if (r_gnt0 && (r_gcnt0 != '1)) r_gcnt0 <= r_gcnt0 + CW'(1);
      if (r_gnt1 && (r_gcnt1 != '1)) r_gcnt1 <= r_gcnt1 + CW'(1);
    end
  end

  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;
  assign bus.gnt0      = r_gnt0;
  assign bus.gnt1      = r_gnt1;
  assign bus.rvalid0   = r_rvalid0;
  assign bus.rvalid1   = r_rvalid1;
  assign bus.rdata0    = r_rdata0;
  assign bus.rdata1    = r_rdata1;
  assign bus.gcnt0     = r_gcnt0;
  assign bus.gcnt1     = r_gcnt1;

endmodule
`default_nettype wire
